// File: rtl/laser310_bank_mapper.sv
// Laser310 SRAM page mapper: fixed B800H window on page 0, banked C000H window on a
// page chosen through a synchronised IO control register with write-protect and disable.
module laser310_bank_mapper #(
    parameter int         BANK_BITS   = 2,
    parameter logic [3:0] IO_PORT     = 4'h7,
    parameter int         RESET_BANK  = 1,
    parameter int         LED_STRETCH = 2500000
) (
    input  logic                 clk,
    input  logic                 RESET,
    input  logic [4:0]           Addr,
    input  logic [3:0]           AddrIO,
    input  logic [7:0]           D,
    input  logic                 MREQ_N,
    input  logic                 IORQ_N,
    input  logic                 RD_N,
    input  logic                 WR_N,
    output logic [BANK_BITS-1:0] RAM_AHI,
    output logic                 RAM_CS_N,
    output logic                 RAM_OE_N,
    output logic                 RAM_WE_N,
    output logic [7:0]           DOUT,
    output logic                 DOUT_OE,
    output logic [BANK_BITS-1:0] bank,
    output logic                 wp,
    output logic                 led1,
    output logic                 led2
);
    localparam int                   CW       = $clog2(LED_STRETCH + 1);
    localparam logic [CW-1:0]        LED_LOAD = CW'(LED_STRETCH);
    localparam logic [BANK_BITS-1:0] RST_BANK = BANK_BITS'(RESET_BANK);

    logic [BANK_BITS-1:0] r_bank;
    logic                 r_wp, r_dis;
    logic                 r_s1, r_s2, r_s3;
    logic [7:0]           r_d1, r_d2;
    logic [CW-1:0]        r_cnt1, r_cnt2;

    logic w_memcyc, w_fixed, w_banked, w_viol, w_bank_sel, w_sel;
    logic w_iow, w_iord, w_commit;
    logic w_unused_d;
    logic [7:0] w_dout;

    assign w_memcyc   = !MREQ_N && IORQ_N && (RD_N != WR_N);
    assign w_fixed    = w_memcyc && (Addr == 5'b10111);
    assign w_banked   = w_memcyc && (Addr[4:3] == 2'b11) && !r_dis;
    assign w_viol     = w_banked && r_wp && !WR_N;
    assign w_bank_sel = w_banked && !w_viol;
    assign w_sel      = w_fixed || w_bank_sel;

    assign w_iow  = !IORQ_N && MREQ_N && !WR_N && RD_N && (AddrIO == IO_PORT);
    assign w_iord = !IORQ_N && MREQ_N && !RD_N && WR_N && (AddrIO == IO_PORT);

    // Rising edge of the synchronised strobe: a held strobe commits once.
    assign w_commit = r_s2 && !r_s3;

    assign RAM_CS_N = RESET || !w_sel;
    assign RAM_OE_N = RESET || !w_sel || RD_N;
    assign RAM_WE_N = RESET || !w_sel || WR_N;
    assign RAM_AHI  = w_banked ? r_bank : '0;

    always_comb begin
        w_dout                = '0;
        w_dout[7]             = r_dis;
        w_dout[6]             = r_wp;
        w_dout[BANK_BITS-1:0] = r_bank;
    end

    assign DOUT       = w_dout;
    assign DOUT_OE    = w_iord && !RESET;
    assign bank       = r_bank;
    assign wp         = r_wp;
    assign led1       = (r_cnt1 != '0);
    assign led2       = (r_cnt2 != '0);
    assign w_unused_d = ^r_d2;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_d1   <= '0;
            r_d2   <= '0;
            r_bank <= RST_BANK;
            r_wp   <= 1'b0;
            r_dis  <= 1'b0;
        end else begin
            r_s1 <= w_iow;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            r_d1 <= D;
            r_d2 <= r_d1;
            if (w_commit) begin
                r_bank <= r_d2[BANK_BITS-1:0];
                r_wp   <= r_d2[6];
                r_dis  <= r_d2[7];
            end
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_cnt1 <= '0;
            r_cnt2 <= '0;
        end else begin
            if (w_bank_sel)
                r_cnt1 <= LED_LOAD;
            else if (r_cnt1 != '0)
                r_cnt1 <= r_cnt1 - CW'(1);
            if (w_commit || w_viol)
                r_cnt2 <= LED_LOAD;
            else if (r_cnt2 != '0)
                r_cnt2 <= r_cnt2 - CW'(1);
        end
    end
endmodule
